// File: rtl/stall_mem_responder_if.sv
// Data-memory request/response bundle between the memory stage and the memory responder.
interface stall_mem_responder_if;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        rd;
  logic        wr;
  logic [15:0] data_out;
  logic        done;
  logic        stall;
  logic        err;

  modport master (
    output addr, data_in, rd, wr,
    input  data_out, done, stall, err
  );

  modport slave (
    input  addr, data_in, rd, wr,
    output data_out, done, stall, err
  );
endinterface

// File: rtl/stall_mem_responder.sv
// Multi-cycle word memory: accepts one read or write at a time, stalls the requester
// for LATENCY cycles and pulses done when the access completes.
module stall_mem_responder #(
  parameter int unsigned LATENCY   = 4,  // 1..15
  parameter int unsigned ADDR_BITS = 8
) (
  input logic                  clk,
  input logic                  rst,
  stall_mem_responder_if.slave bus
);

  localparam int unsigned Words = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q;
  logic [15:0]          data_q;
  logic                 wr_q;
  logic [15:0]          data_out_q;
  logic                 err_q;
  logic [15:0]          mem_q [Words];

  logic                 hi_zero;
  logic                 req_legal;
  logic                 accept;
  logic                 set_err;
  logic                 enter_done;
  logic [ADDR_BITS-1:0] acc_addr;
  logic [15:0]          acc_data;
  logic                 acc_wr;

  // Request legality and the operands of the access that completes on this edge.
  // With LATENCY==1 the access happens on the accept edge, so it takes the live bus values.
  always_comb begin
    hi_zero   = ((bus.addr >> (ADDR_BITS + 1)) == 16'd0);
    req_legal = (bus.rd ^ bus.wr) & ~bus.addr[0] & hi_zero;
    if (state_q == StIdle) begin
      acc_addr = bus.addr[ADDR_BITS:1];
      acc_data = bus.data_in;
      acc_wr   = bus.wr;
    end else begin
      acc_addr = addr_q;
      acc_data = data_q;
      acc_wr   = wr_q;
    end
  end

  // Next-state logic for the IDLE/BUSY/DONE sequencer and its down-counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    set_err = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_legal) begin
          accept  = 1'b1;
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? StDone : StBusy;
        end else if (bus.rd | bus.wr) begin
          set_err = 1'b1;
        end
      end
      StBusy: begin
        if (cnt_q == 4'd1) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    enter_done = (state_d == StDone) && (state_q != StDone);
  end

  // State, latched request, sticky error, read data and the array itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      data_out_q <= '0;
      err_q      <= 1'b0;
      for (int unsigned i = 0; i < Words; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q <= bus.addr[ADDR_BITS:1];
        data_q <= bus.data_in;
        wr_q   <= bus.wr;
      end
      if (set_err) begin
        err_q <= 1'b1;
      end
      if (enter_done) begin
        if (acc_wr) begin
          mem_q[acc_addr] <= acc_data;
        end else begin
          data_out_q <= mem_q[acc_addr];
        end
      end
    end
  end

  // Stall covers the accept cycle combinationally and is forced low during reset.
  always_comb begin
    bus.stall    = ~rst & (((state_q == StIdle) & req_legal) | (state_q == StBusy));
    bus.done     = (state_q == StDone);
    bus.data_out = data_out_q;
    bus.err      = err_q;
  end

endmodule

// File: tb/tb_stall_mem_responder.sv
// Directed bench for stall_mem_responder: a LATENCY=4 instance driven from a vector table
// and hand sequences, plus a LATENCY=1 instance for the back-to-back case.
module tb_stall_mem_responder;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        stall;
    logic        done;
    logic [15:0] dout;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  stall_mem_responder_if if4 ();
  stall_mem_responder_if if1 ();

  stall_mem_responder #(.LATENCY(4), .ADDR_BITS(8)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  stall_mem_responder #(.LATENCY(1), .ADDR_BITS(8)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one cycle's inputs on the chosen instance, check outputs mid-cycle, then clock.
  task automatic apply(input bit sel1, input vec_t v, input string tag);
    logic [15:0] st, dn, dout, er;
    if (sel1) begin
      if1.rd = v.rd; if1.wr = v.wr; if1.addr = v.addr; if1.data_in = v.din;
    end else begin
      if4.rd = v.rd; if4.wr = v.wr; if4.addr = v.addr; if4.data_in = v.din;
    end
    @(negedge clk);
    if (sel1) begin
      st = 16'(if1.stall); dn = 16'(if1.done); dout = if1.data_out; er = 16'(if1.err);
    end else begin
      st = 16'(if4.stall); dn = 16'(if4.done); dout = if4.data_out; er = 16'(if4.err);
    end
    chk({tag, ".stall"}, st, 16'(v.stall));
    chk({tag, ".done"}, dn, 16'(v.done));
    chk({tag, ".dout"}, dout, v.dout);
    chk({tag, ".err"}, er, 16'(v.err));
    @(posedge clk);
    #1;
  endtask

  // Full read on the LATENCY=4 instance: accept, three busy cycles, done.
  task automatic read4(input logic [15:0] a, input logic [15:0] prev, input logic [15:0] exp,
                       input logic e, input string tag);
    apply(1'b0, '{1'b1, 1'b0, a, 16'h0, 1'b1, 1'b0, prev, e}, {tag, ".acc"});
    for (int i = 1; i < 4; i++) apply(1'b0, '{1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, prev, e},
                                      $sformatf("%s.busy%0d", tag, i));
    apply(1'b0, '{1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, exp, e}, {tag, ".done"});
  endtask

  vec_t tbl [27];
  logic [15:0] vals [3];
  logic [15:0] prev1;

  initial begin
    if4.rd = 0; if4.wr = 0; if4.addr = 0; if4.data_in = 0;
    if1.rd = 0; if1.wr = 0; if1.addr = 0; if1.data_in = 0;

    //            rd    wr    addr      din       stall done  dout      err
    // never-written read
    tbl[0]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0};
    // write BEEF to 0x0010; dout unchanged by the write
    tbl[5]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0};
    // read it back
    tbl[10] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0};
    // write presented in the DONE cycle must be ignored
    tbl[14] = '{1'b0, 1'b1, 16'h0010, 16'h1111, 1'b0, 1'b1, 16'hBEEF, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 1'b0};
    // illegal requests: both ops, odd address, out of range
    tbl[16] = '{1'b1, 1'b1, 16'h0010, 16'h2222, 1'b0, 1'b0, 16'hBEEF, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 1'b1};
    tbl[18] = '{1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 1'b1};
    tbl[19] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 1'b1};
    tbl[20] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 1'b1};
    // legal read still completes; 0x0010 untouched by ignored write
    tbl[21] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 1'b1};
    tbl[22] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 1'b1};
    tbl[23] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 1'b1};
    tbl[24] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 1'b1};
    tbl[25] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1'b1};
    tbl[26] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 1'b1};

    // Reset, with a legal request present: stall must stay low while rst is high.
    if4.rd = 1'b1; if4.addr = 16'h0010;
    @(negedge clk);
    chk("rst.stall_low", 16'(if4.stall), 16'h0);
    repeat (2) @(posedge clk);
    #1;
    if4.rd = 1'b0; if4.addr = 16'h0;
    rst = 1'b0;
    apply(1'b0, '{1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0000, 1'b0}, "reset");

    for (int i = 0; i < 27; i++) apply(1'b0, tbl[i], $sformatf("tbl%0d", i));

    // Mid-BUSY input changes must not disturb the latched write.
    apply(1'b0, '{1'b0, 1'b1, 16'h0004, 16'h1234, 1'b1, 1'b0, 16'hBEEF, 1'b1}, "hold.acc");
    apply(1'b0, '{1'b1, 1'b0, 16'h0006, 16'hFFFF, 1'b1, 1'b0, 16'hBEEF, 1'b1}, "hold.b1");
    apply(1'b0, '{1'b0, 1'b1, 16'h0006, 16'hFFFF, 1'b1, 1'b0, 16'hBEEF, 1'b1}, "hold.b2");
    apply(1'b0, '{1'b1, 1'b1, 16'h0011, 16'h5555, 1'b1, 1'b0, 16'hBEEF, 1'b1}, "hold.b3");
    apply(1'b0, '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1'b1}, "hold.done");
    apply(1'b0, '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 1'b1}, "hold.idle");
    read4(16'h0004, 16'hBEEF, 16'h1234, 1'b1, "rd4");
    read4(16'h0006, 16'h1234, 16'h0000, 1'b1, "rd6");

    // Reset in cycle 2 of a write: no done, write discarded, array and err cleared.
    apply(1'b0, '{1'b0, 1'b1, 16'h0008, 16'hAAAA, 1'b1, 1'b0, 16'h0000, 1'b1}, "abort.acc");
    apply(1'b0, '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1}, "abort.b1");
    rst = 1'b1;
    @(negedge clk);
    chk("abort.rst_stall", 16'(if4.stall), 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) apply(1'b0, '{1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0},
                                      $sformatf("abort.idle%0d", i));
    read4(16'h0008, 16'h0000, 16'h0000, 1'b0, "rd8");
    read4(16'h0010, 16'h0000, 16'h0000, 1'b0, "rd10_cleared");

    // LATENCY=1: alternate write/read to the top word, done every second cycle.
    vals[0] = 16'h1357; vals[1] = 16'hCAFE; vals[2] = 16'h0001;
    prev1 = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, '{1'b0, 1'b1, 16'h01FE, vals[i], 1'b1, 1'b0, prev1, 1'b0},
            $sformatf("l1.wr%0d", i));
      apply(1'b1, '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, prev1, 1'b0},
            $sformatf("l1.wdone%0d", i));
      apply(1'b1, '{1'b1, 1'b0, 16'h01FE, 16'h0000, 1'b1, 1'b0, prev1, 1'b0},
            $sformatf("l1.rd%0d", i));
      apply(1'b1, '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, vals[i], 1'b0},
            $sformatf("l1.rdone%0d", i));
      prev1 = vals[i];
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
